mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified, variable-latency memory port between the pipeline's instruction-fetch (IF) and data-access (MEM) stages. It arbitrates between the two requesters and runs a req/ready handshake to memory. Returned words are buffered until the pipeline can consume them. A single `stall` output freezes the pc register and all pipeline registers until every outstanding request of the current cycle has completed. It sits between the `mips` core and the system memory, replacing the separate instruction and data memories.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch wanted; held high while `stall`
- `if_addr`  in  AW  fetch address (`pc`)
- `if_rdata`  out  DW  fetched instruction; valid while `if_ok`
- `if_ok`  out  1  fetch satisfied this cycle (completing now or held)
- `d_req`  in  1  data access wanted; held while `stall`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data; valid while `d_ok` and load
- `d_ok`  out  1  data access satisfied this cycle
- `stall`  out  1  pipeline freeze
- `m_req`  out  1  memory request
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data; valid with `m_ready`
- `m_ready`  in  1  memory completes the current request

## Operation
- The FSM has three states: IDLE, IFETCH and DACCESS. The state is registered.
- Held flags: `if_held` and `d_held`. Hold registers: `if_buf` and `d_buf`.
- A port is eligible when its req is high, its held flag is 0, and it is not in flight.
- Grant from IDLE: if both ports are eligible, DACCESS wins. Otherwise grant the eligible port. Otherwise stay in IDLE.
- At grant, latch the address; for a data grant also latch `we` and `wdata` into the request register.
- In IFETCH or DACCESS:
  - `m_req`=1, and `m_addr`, `m_we`, `m_wdata` come from the latched request. These are stable until `m_ready`.
  - A requester dropping its req mid-access has no effect; the access completes.
- Completion (`m_ready`=1 in a busy state):
  - The completing port's `ok` is 1 this cycle and its `rdata` = `m_rdata` (combinational pass-through).
  - `m_rdata` is written into that port's buffer.
  - If `advance` is 0 this cycle, the port's held flag is set.
  - Next state: if the other port is eligible, go straight to its busy state (alternation, no starvation). Otherwise go to IDLE.
  - The completing port is never regranted in its completion cycle.
- `if_ok` = `if_held` OR (IFETCH and `m_ready`). `d_ok` is defined the same way. Held data is driven from the buffer.
- `advance` = (¬`if_req` OR `if_ok`) AND (¬`d_req` OR `d_ok`).
- `stall` = ¬`advance`. When `advance`=1, both held flags clear.
- For stores, `d_rdata` is don't-care. `d_ok` behaves the same as for loads.
- `m_ready` in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `m_req`, `m_we` = 0; `m_addr`, `m_wdata` = 0.
  - held flags = 0; buffers = 0.
  - `if_ok`, `d_ok` = 0; `if_rdata`, `d_rdata` = 0.
  - `stall` follows its equation, so it is 1 if `if_req` is high during reset.
- Reset mid-access: the transaction is abandoned with no retry. A late `m_ready` is ignored.
- Grant at cycle t means `m_req`=1 from t+1. The earliest completion is t+1 (memory with `m_ready` tied to 1).
- Throughput: zero-wait memory with fetch only gives 1 instruction per 2 cycles. With fetch plus load it gives 1 per 3 cycles.
- A memory wait of N cycles adds N cycles of `stall` for that access.
- Both ports are served in the same pipeline cycle only through the held flags. The first result is buffered and `stall` stays high until the second result arrives.
- `stall` is combinational from state, the held flags, reqs and `m_ready`. It has no loop through `m_req`.

## Structure
- Shared package `mips_mem_pkg` holds:
  - state encoding: IDLE=2'b00, IFETCH=2'b01, DACCESS=2'b10;
  - `AW`/`DW` defaults.
- Buffers and the request register reuse the existing `flopenr` enable-flop with synchronous reset.
- No other sub-module. The FSM, arbitration and ok/stall logic stay in one module.

## Test plan
- Fetch only, `m_ready`=1, `if_addr`=0x0, 0x4, 0x8 → `m_addr` sequence 0x0, 0x4, 0x8. `if_ok` pulses every 2nd cycle with `if_rdata`=`m_rdata`.
- Simultaneous `if_req` (0x10) and load `d_req` (0x100), with `m_rdata` 0xAAAA then 0xBBBB → DACCESS first:
  - `d_ok` with 0xAAAA, `d_held` set, `stall`=1;
  - next cycle IFETCH, `if_ok` with 0xBBBB, `stall`=0;
  - `d_rdata` still 0xAAAA.
- Store 0xDEADBEEF to 0x200 with `m_ready` delayed 3 cycles → `m_we`=1 and `m_addr`/`m_wdata` stable for 3 cycles. `stall`=1 for 3 cycles, then `d_ok`.
- `d_req` dropped one cycle after grant → access still completes. No second `m_req` to the same address.
- Reset asserted during DACCESS wait, `m_ready` arriving 1 cycle after reset deasserts → state IDLE, `m_req`=0, no `d_ok`, ready ignored.
- Continuous fetch and data reqs across 10 accesses → grants alternate IFETCH/DACCESS. Neither port waits more than one other access.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the unified memory arbiter
// Purpose: FSM state encoding and default bus widths used by mem_arbiter.
// Ports: none (package).
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IFETCH  = 2'b01,
    DACCESS = 2'b10
  } state_t;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enable flop with synchronous active-high reset
// Purpose: generic WIDTH-bit register, loads d when en is high.
// Ports: clk, reset (sync, active-high), en (load enable), d (next value), q (stored value).
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one variable-latency memory port between IF and MEM stages
// Purpose: arbitrates fetch and data requests onto a req/ready memory port, buffers
//   completed results until the pipeline can advance, and drives the pipeline stall.
// Ports:
//   clk, reset                          clock, sync active-high reset
//   if_req, if_addr / if_rdata, if_ok   instruction-fetch requester
//   d_req, d_we, d_addr, d_wdata /
//   d_rdata, d_ok                       data-access requester
//   stall                               freeze pc and pipeline registers
//   m_req, m_we, m_addr, m_wdata /
//   m_rdata, m_ready                    shared memory port
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ok,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ok,
  output logic          stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  localparam int RW = 1 + AW + DW;

  state_t        state_q, state_d;
  logic          if_held_q, if_held_d;
  logic          d_held_q, d_held_d;
  logic          if_done, d_done;
  logic          if_elig, d_elig;
  logic          grant_if, grant_d;
  logic          advance;
  logic [RW-1:0] req_d, req_q;
  logic          req_we_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q;
  logic [DW-1:0] if_buf_q, d_buf_q;

  always_comb begin
    if_done  = (state_q == IFETCH)  && m_ready;
    d_done   = (state_q == DACCESS) && m_ready;

    // A port already being served is not eligible, so the completing port
    // can never be regranted in its own completion cycle.
    if_elig  = if_req && !if_held_q && (state_q != IFETCH);
    d_elig   = d_req  && !d_held_q  && (state_q != DACCESS);

    if_ok    = if_held_q || if_done;
    d_ok     = d_held_q  || d_done;
    if_rdata = if_done ? m_rdata : if_buf_q;
    d_rdata  = d_done  ? m_rdata : d_buf_q;

    advance  = (!if_req || if_ok) && (!d_req || d_ok);
    stall    = !advance;

    // A result that cannot be consumed yet is parked until the other port finishes.
    if_held_d = advance ? 1'b0 : (if_held_q || if_done);
    d_held_d  = advance ? 1'b0 : (d_held_q  || d_done);

    grant_if = 1'b0;
    grant_d  = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (d_elig)       grant_d  = 1'b1;
        else if (if_elig) grant_if = 1'b1;
      end
      IFETCH: begin
        if (m_ready) begin
          if (d_elig) grant_d = 1'b1;
          else        state_d = IDLE;
        end
      end
      DACCESS: begin
        if (m_ready) begin
          if (if_elig) grant_if = 1'b1;
          else         state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_d)       state_d = DACCESS;
    else if (grant_if) state_d = IFETCH;

    req_d = grant_d ? {d_we, d_addr, d_wdata} : {1'b0, if_addr, {DW{1'b0}}};

    m_req   = (state_q == IFETCH) || (state_q == DACCESS);
    m_we    = (state_q == DACCESS) && req_we_q;
    m_addr  = req_addr_q;
    m_wdata = req_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      if_held_q <= 1'b0;
      d_held_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_held_q <= if_held_d;
      d_held_q  <= d_held_d;
    end
  end

  flopenr #(.WIDTH(RW)) u_req_reg (
    .clk   (clk),
    .reset (reset),
    .en    (grant_if || grant_d),
    .d     (req_d),
    .q     (req_q)
  );

  assign {req_we_q, req_addr_q, req_wdata_q} = req_q;

  flopenr #(.WIDTH(DW)) u_if_buf (
    .clk   (clk),
    .reset (reset),
    .en    (if_done),
    .d     (m_rdata),
    .q     (if_buf_q)
  );

  flopenr #(.WIDTH(DW)) u_d_buf (
    .clk   (clk),
    .reset (reset),
    .en    (d_done),
    .d     (m_rdata),
    .q     (d_buf_q)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Purpose: cycle-by-cycle vector table plus directed multi-cycle sequences.
// Ports: none (top-level bench).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, m_ready;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ok, d_ok, stall, m_req, m_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ok    (if_ok),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ok     (d_ok),
    .stall    (stall),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready)
  );

  typedef struct {
    logic        rst, ifr, dr, dwe, mrdy;
    logic [31:0] ifa, da, dwd, mrd;
    logic        eif_ok, ed_ok, estall, emreq, emwe;
    logic [31:0] emaddr, emwd, eif_rd, ed_rd;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic ifr, input logic [31:0] ifa,
    input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
    input logic [31:0] mrd, input logic mrdy,
    input logic eifok, input logic edok, input logic estall, input logic emreq,
    input logic emwe, input logic [31:0] emaddr, input logic [31:0] emwd,
    input logic [31:0] eifrd, input logic [31:0] edrd);
    vec_t r;
    r.rst = rst; r.ifr = ifr; r.ifa = ifa; r.dr = dr; r.dwe = dwe; r.da = da;
    r.dwd = dwd; r.mrd = mrd; r.mrdy = mrdy;
    r.eif_ok = eifok; r.ed_ok = edok; r.estall = estall; r.emreq = emreq;
    r.emwe = emwe; r.emaddr = emaddr; r.emwd = emwd; r.eif_rd = eifrd; r.ed_rd = edrd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [31:0] mrd, input logic mrdy);
    @(negedge clk);
    reset = rst; if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe;
    d_addr = da; d_wdata = dwd; m_rdata = mrd; m_ready = mrdy;
    #1;
  endtask

  vec_t tbl[18];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int          n_acc;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;

    //            rst ifr ifa     dr we da      dwd           mrd      rdy  ifok dok stl mrq mwe maddr   mwd           ifrd     drd
    tbl[0]  = v(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,    0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[1]  = v(1, 1, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,    0,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[2]  = v(0, 1, 32'h0,  0, 0, 32'h0,   32'h0,        32'h11,   1,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[3]  = v(0, 1, 32'h0,  0, 0, 32'h0,   32'h0,        32'h11,   1,   1, 0, 0, 1, 0, 32'h0,   32'h0,        32'h11,   32'h0);
    tbl[4]  = v(0, 1, 32'h4,  0, 0, 32'h0,   32'h0,        32'h22,   1,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[5]  = v(0, 1, 32'h4,  0, 0, 32'h0,   32'h0,        32'h22,   1,   1, 0, 0, 1, 0, 32'h4,   32'h0,        32'h22,   32'h0);
    tbl[6]  = v(0, 1, 32'h8,  0, 0, 32'h0,   32'h0,        32'h33,   1,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[7]  = v(0, 1, 32'h8,  0, 0, 32'h0,   32'h0,        32'h33,   1,   1, 0, 0, 1, 0, 32'h8,   32'h0,        32'h33,   32'h0);
    tbl[8]  = v(0, 1, 32'h10, 1, 0, 32'h100, 32'h0,        32'hAAAA, 1,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[9]  = v(0, 1, 32'h10, 1, 0, 32'h100, 32'h0,        32'hAAAA, 1,   0, 1, 1, 1, 0, 32'h100, 32'h0,        32'h0,    32'hAAAA);
    tbl[10] = v(0, 1, 32'h10, 1, 0, 32'h100, 32'h0,        32'hBBBB, 1,   1, 1, 0, 1, 0, 32'h10,  32'h0,        32'hBBBB, 32'hAAAA);
    tbl[11] = v(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,    0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[12] = v(0, 0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    0,   0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);
    tbl[13] = v(0, 0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    0,   0, 0, 1, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    32'h0);
    tbl[14] = v(0, 0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    0,   0, 0, 1, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    32'h0);
    tbl[15] = v(0, 0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    0,   0, 0, 1, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    32'h0);
    tbl[16] = v(0, 0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 32'h5555, 1,   0, 1, 0, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0,    32'h0);
    tbl[17] = v(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,    0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].ifr, tbl[i].ifa, tbl[i].dr, tbl[i].dwe,
            tbl[i].da, tbl[i].dwd, tbl[i].mrd, tbl[i].mrdy);
      chk($sformatf("row%0d if_ok", i), {31'b0, if_ok}, {31'b0, tbl[i].eif_ok});
      chk($sformatf("row%0d d_ok", i),  {31'b0, d_ok},  {31'b0, tbl[i].ed_ok});
      chk($sformatf("row%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].estall});
      chk($sformatf("row%0d m_req", i), {31'b0, m_req}, {31'b0, tbl[i].emreq});
      chk($sformatf("row%0d m_we", i),  {31'b0, m_we},  {31'b0, tbl[i].emwe});
      if (tbl[i].rst)
        chk($sformatf("row%0d if_rdata", i), if_rdata, 32'h0);
      if (tbl[i].emreq) begin
        chk($sformatf("row%0d m_addr", i),  m_addr,  tbl[i].emaddr);
        chk($sformatf("row%0d m_wdata", i), m_wdata, tbl[i].emwd);
      end
      if (tbl[i].eif_ok)
        chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].eif_rd);
      if (tbl[i].ed_ok && !tbl[i].dwe)
        chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].ed_rd);
    end

    // d_req dropped right after grant: access still completes exactly once.
    drive(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, 32'h0, 0);
    chk("drop grant stall", {31'b0, stall}, 32'h1);
    drive(0, 0, 32'h0, 0, 0, 32'h300, 32'h0, 32'h0, 0);
    chk("drop m_req", {31'b0, m_req}, 32'h1);
    chk("drop m_addr", m_addr, 32'h300);
    chk("drop stall", {31'b0, stall}, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h300, 32'h0, 32'h77, 1);
    chk("drop d_ok", {31'b0, d_ok}, 32'h1);
    chk("drop d_rdata", d_rdata, 32'h77);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 32'h0, 0, 0, 32'h300, 32'h0, 32'h77, 1);
      chk($sformatf("drop after m_req %0d", k), {31'b0, m_req}, 32'h0);
      chk($sformatf("drop after d_ok %0d", k), {31'b0, d_ok}, 32'h0);
    end

    // Reset during a DACCESS wait, late m_ready afterwards is ignored.
    drive(0, 0, 32'h0, 1, 0, 32'h400, 32'h0, 32'h0, 0);
    drive(0, 0, 32'h0, 1, 0, 32'h400, 32'h0, 32'h0, 0);
    chk("rst pre m_req", {31'b0, m_req}, 32'h1);
    drive(1, 0, 32'h0, 0, 0, 32'h400, 32'h0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 0, 32'h400, 32'h0, 32'h99, 1);
    chk("rst late m_req", {31'b0, m_req}, 32'h0);
    chk("rst late d_ok", {31'b0, d_ok}, 32'h0);
    chk("rst late stall", {31'b0, stall}, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    chk("rst after m_req", {31'b0, m_req}, 32'h0);

    // Continuous fetch + load with irregular memory waits: completions alternate.
    exp_addr = 32'h600;
    n_acc    = 0;
    for (int k = 0; k < 80 && n_acc < 10; k++) begin
      drive(0, 1, 32'h500, 1, 0, 32'h600, 32'h0, 32'h1000 + k, (k % 3) != 0);
      if (m_req && m_ready) begin
        chk($sformatf("alt addr %0d", n_acc), m_addr, exp_addr);
        if (exp_addr == 32'h500) begin
          chk($sformatf("alt d_ok held %0d", n_acc), {31'b0, d_ok}, 32'h1);
          chk($sformatf("alt stall clear %0d", n_acc), {31'b0, stall}, 32'h0);
        end else begin
          chk($sformatf("alt stall held %0d", n_acc), {31'b0, stall}, 32'h1);
        end
        exp_addr = (exp_addr == 32'h600) ? 32'h500 : 32'h600;
        n_acc++;
      end
    end
    chk("alt access count", n_acc, 10);

    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
